// File: rtl/ser_tx.sv
// rtl/ser_tx.sv - command-driven 8N1 serial transmitter with polled status byte
module ser_tx #(
    parameter logic [7:0] DefaultDiv = 8'h03
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] inst,
    input  logic        inst_en,
    output logic        tx,
    output logic [7:0]  status,
    output logic        ready
);

    localparam logic [3:0] OP_LDD = 4'h1;
    localparam logic [3:0] OP_LDB = 4'h2;
    localparam logic [3:0] OP_SND = 4'h3;
    localparam logic [3:0] OP_CLO = 4'h4;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state;
    logic [7:0]  holding;
    logic [7:0]  shift;
    logic [7:0]  div;
    logic [7:0]  active_div;
    logic [7:0]  baud;
    logic [2:0]  bit_cnt;
    logic        pending;
    logic        ovf;
    logic        tx_r;

    logic [3:0]  op;
    logic        busy;
    logic        snd;
    logic        last_tick;
    logic        stop_end;
    logic        launch;

    assign op        = inst[11:8];
    assign busy      = (state != IDLE);
    assign snd       = inst_en && (op == OP_SND);
    assign last_tick = (baud == active_div);
    assign stop_end  = (state == STOP) && last_tick;
    // A request landing in the final stop cycle is folded straight into a relaunch.
    assign launch    = ((state == IDLE) && snd) || (stop_end && (pending || snd));

    assign tx     = tx_r;
    assign status = {5'b0, ovf, pending, busy};
    assign ready  = ~busy & ~pending;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            holding    <= 8'h00;
            shift      <= 8'h00;
            div        <= DefaultDiv;
            active_div <= DefaultDiv;
            baud       <= 8'h00;
            bit_cnt    <= 3'd0;
            pending    <= 1'b0;
            ovf        <= 1'b0;
            tx_r       <= 1'b1;
        end else begin
            if (inst_en) begin
                case (op)
                    OP_LDD:  holding <= inst[7:0];
                    OP_LDB:  div     <= inst[7:0];
                    OP_CLO:  ovf     <= 1'b0;
                    default: ;
                endcase
            end

            if (snd && busy && pending)
                ovf <= 1'b1;
            if (snd && busy && !pending && !stop_end)
                pending <= 1'b1;

            case (state)
                IDLE: ;
                START: begin
                    if (last_tick) begin
                        state   <= DATA;
                        tx_r    <= shift[0];
                        baud    <= 8'h00;
                        bit_cnt <= 3'd0;
                    end else begin
                        baud <= baud + 8'd1;
                    end
                end
                DATA: begin
                    if (last_tick) begin
                        baud  <= 8'h00;
                        shift <= {1'b0, shift[7:1]};
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                            tx_r  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx_r    <= shift[1];
                        end
                    end else begin
                        baud <= baud + 8'd1;
                    end
                end
                STOP: begin
                    if (last_tick) begin
                        state <= IDLE;
                        baud  <= 8'h00;
                    end else begin
                        baud <= baud + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Frame launch samples holding/div now, so late LDD/LDB updates are honoured.
            if (launch) begin
                shift      <= holding;
                active_div <= div;
                baud       <= 8'h00;
                bit_cnt    <= 3'd0;
                state      <= START;
                tx_r       <= 1'b0;
                pending    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ser_tx.sv
// tb/tb_ser_tx.sv - scoreboard testbench for ser_tx
module tb_ser_tx;

    logic        clock;
    logic        reset;
    logic [11:0] inst;
    logic        inst_en;
    logic        tx;
    logic [7:0]  status;
    logic        ready;

    ser_tx #(.DefaultDiv(8'h03)) dut (
        .clock   (clock),
        .reset   (reset),
        .inst    (inst),
        .inst_en (inst_en),
        .tx      (tx),
        .status  (status),
        .ready   (ready)
    );

    int n_cmp;
    int n_fail;
    int frames;
    int busy_cnt;

    logic [7:0] exp_data[$];
    logic [7:0] exp_div[$];

    logic       m_active;
    logic [7:0] m_data;
    logic [7:0] m_div;
    logic [7:0] m_got;
    int         m_idx;
    int         m_bad;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [7:0] imm);
        @(posedge clock);
        #1;
        inst    = {op, imm};
        inst_en = 1'b1;
        @(posedge clock);
        #1;
        inst_en = 1'b0;
        inst    = 12'h000;
    endtask

    task automatic issue_dis(input logic [3:0] op, input logic [7:0] imm);
        @(posedge clock);
        #1;
        inst    = {op, imm};
        inst_en = 1'b0;
        @(posedge clock);
        #1;
        inst = 12'h000;
    endtask

    task automatic expect_frame(input logic [7:0] data, input logic [7:0] d);
        exp_data.push_back(data);
        exp_div.push_back(d);
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clock);
            if (!status[0]) break;
        end
        check("wait_idle", {31'd0, status[0]}, 32'd0);
    endtask

    initial begin
        busy_cnt = 0;
        forever begin
            @(negedge clock);
            if (reset && status[0]) busy_cnt++;
        end
    end

    // Monitor: re-times every frame on tx against the queued payload and divisor.
    initial begin
        int per;
        int bitpos;
        logic ebit;
        m_active = 1'b0;
        frames   = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                m_active = 1'b0;
                continue;
            end
            if (!m_active && tx == 1'b0) begin
                if (exp_data.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got start bit expected idle line");
                    m_data = 8'h00;
                    m_div  = 8'h00;
                end else begin
                    m_data = exp_data.pop_front();
                    m_div  = exp_div.pop_front();
                end
                m_active = 1'b1;
                m_idx    = 0;
                m_bad    = 0;
                m_got    = 8'h00;
            end
            if (m_active) begin
                per    = int'(m_div) + 1;
                bitpos = m_idx / per;
                if (bitpos == 0)      ebit = 1'b0;
                else if (bitpos == 9) ebit = 1'b1;
                else                  ebit = m_data[bitpos-1];
                if (tx !== ebit) m_bad++;
                if (bitpos >= 1 && bitpos <= 8 && (m_idx % per) == 0)
                    m_got[bitpos-1] = tx;
                m_idx++;
                if (m_idx == 10 * per) begin
                    check("frame_data", {24'd0, m_got}, {24'd0, m_data});
                    check("frame_shape", m_bad, 0);
                    frames++;
                    m_active = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int f0;
        n_cmp   = 0;
        n_fail  = 0;
        reset   = 1'b0;
        inst    = 12'h000;
        inst_en = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_status", {24'd0, status}, 32'h00);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_ready", {31'd0, ready}, 32'd1);
        #1 reset = 1'b1;

        // A5 at two clocks per bit
        issue(4'h2, 8'h01);
        issue(4'h1, 8'hA5);
        expect_frame(8'hA5, 8'h01);
        base = busy_cnt;
        issue(4'h3, 8'h00);
        @(negedge clock);
        check("t1_first_cycle", {23'd0, tx, status}, {23'd0, 1'b0, 8'h01});
        wait_idle(200);
        check("t1_busy_len", busy_cnt - base, 20);
        check("t1_status_end", {24'd0, status}, 32'h00);

        // default divisor after reset, all-zero payload
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        #1 reset = 1'b1;
        issue(4'h1, 8'h00);
        expect_frame(8'h00, 8'h03);
        base = busy_cnt;
        issue(4'h3, 8'h00);
        @(negedge clock);
        check("t2_ready_busy", {31'd0, ready}, 32'd0);
        wait_idle(200);
        check("t2_busy_len", busy_cnt - base, 40);
        check("t2_ready_end", {31'd0, ready}, 32'd1);

        // back-to-back frames at one clock per bit
        issue(4'h2, 8'h00);
        issue(4'h1, 8'h3C);
        expect_frame(8'h3C, 8'h00);
        base = busy_cnt;
        issue(4'h3, 8'h00);
        issue(4'h1, 8'hC3);
        expect_frame(8'hC3, 8'h00);
        issue(4'h3, 8'h00);
        @(negedge clock);
        check("t3_pending_status", {24'd0, status}, 32'h03);
        wait_idle(200);
        check("t3_busy_len", busy_cnt - base, 20);
        check("t3_status_end", {24'd0, status}, 32'h00);

        // overflow on third request, cleared by CLO
        issue(4'h2, 8'h03);
        issue(4'h1, 8'h11);
        f0 = frames;
        expect_frame(8'h11, 8'h03);
        issue(4'h3, 8'h00);
        expect_frame(8'h11, 8'h03);
        issue(4'h3, 8'h00);
        issue(4'h3, 8'h00);
        @(negedge clock);
        check("t4_ovf_status", {24'd0, status}, 32'h07);
        wait_idle(300);
        check("t4_frame_count", frames - f0, 2);
        check("t4_ovf_sticky", {24'd0, status}, 32'h04);
        issue(4'h4, 8'h00);
        @(negedge clock);
        check("t4_clo", {24'd0, status}, 32'h00);

        // LDB and LDD mid-frame only affect the next frame
        issue(4'h2, 8'h01);
        issue(4'h1, 8'h5A);
        expect_frame(8'h5A, 8'h01);
        base = busy_cnt;
        issue(4'h3, 8'h00);
        issue(4'h2, 8'h07);
        issue(4'h1, 8'h96);
        expect_frame(8'h96, 8'h07);
        issue(4'h3, 8'h00);
        wait_idle(300);
        check("t5_busy_len", busy_cnt - base, 100);

        // asynchronous reset mid data bit
        issue(4'h2, 8'h03);
        issue(4'h1, 8'h00);
        expect_frame(8'h00, 8'h03);
        issue(4'h3, 8'h00);
        repeat (6) @(negedge clock);
        check("t6_tx_low", {31'd0, tx}, 32'd0);
        #1 reset = 1'b0;
        #1;
        check("t6_async_tx", {31'd0, tx}, 32'd1);
        check("t6_async_status", {24'd0, status}, 32'h00);
        check("t6_async_ready", {31'd0, ready}, 32'd1);
        repeat (2) @(negedge clock);
        #1 reset = 1'b1;

        f0 = frames;
        for (int op = 5; op < 16; op++) issue(op[3:0], 8'hFF);
        issue(4'h0, 8'hFF);
        issue_dis(4'h1, 8'h77);
        issue_dis(4'h2, 8'h77);
        issue_dis(4'h3, 8'h77);
        repeat (4) @(negedge clock);
        check("t7_status", {23'd0, tx, status}, {23'd0, 1'b1, 8'h00});
        check("t7_no_frame", frames - f0, 0);
        expect_frame(8'h00, 8'h03);
        base = busy_cnt;
        issue(4'h3, 8'h00);
        wait_idle(500);
        check("t7_busy_len", busy_cnt - base, 40);

        repeat (4) @(negedge clock);
        check("queue_empty", exp_data.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
